ascon_aead128_blk_fifo: RTL

Parametrised input packer and block FIFO for the Ascon-AEAD128 datapath. It gathers bus-width words (AD or data-block words written through the AXI4-Lite register file) into 128-bit blocks, handles a partial final block with optional Ascon 0x01 padding, and buffers up to DEPTH blocks toward the permutation core on a valid/ready interface. It replaces the fixed single-block AD0..3/DIN0..3 holding registers and allows the host to run ahead of the core.

---
 rtl/ascon_aead128_blk_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ascon_aead128_blk_fifo.sv
// Packs BUS_W words into padded 128-bit Ascon blocks and queues them first-word-fall-through.
// Block is visible one cycle after its completing word; wr_ready drops whenever the FIFO is full.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     clear,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW  = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push = push_vld && (level != FULL_LVL);
  assign do_pop  = pop_rdy && (level != '0);
  assign pop_vld = (level != '0);
  // Empty FIFO presents zeros rather than stale storage.
  assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_dat;
  end
endmodule

module ascon_aead128_blk_fifo #(
  parameter int BUS_W  = 32,
  parameter int DEPTH  = 4,
  parameter int PAD_EN = 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     clear,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [BUS_W-1:0]         wr_data,
  input  logic [BUS_W/8-1:0]       wr_strb,
  input  logic                     wr_last,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [127:0]             blk_data,
  output logic                     blk_last,
  output logic [4:0]               blk_nbytes,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_strb
);
  localparam int WPB = 128 / BUS_W;
  localparam int SB  = BUS_W / 8;
  localparam int LW  = $clog2(WPB);
  localparam int LVW = $clog2(DEPTH) + 1;
  localparam logic [LVW-1:0] FULL_LVL = LVW'(DEPTH);

  typedef struct packed {
    logic         last;
    logic [4:0]   nbytes;
    logic [127:0] data;
  } blk_t;

  logic [127:0]   asm_q, merged, padded;
  logic [LW-1:0]  lane;
  logic           acc, commit, bad, run;
  logic [SB-1:0]  run_mask, keep;
  logic [4:0]     vbytes, nbytes;
  logic [BUS_W-1:0] word_m;
  blk_t           push_dat, pop_dat;

  assign wr_ready = aresetn && (level != FULL_LVL);
  assign acc      = wr_valid && wr_ready && !clear;
  assign commit   = acc && (wr_last || (lane == LW'(WPB-1)));

  always_comb begin
    run      = 1'b1;
    run_mask = '0;
    vbytes   = '0;
    word_m   = '0;
    // Final word: only the contiguous strobe run from byte 0 carries data.
    for (int i = 0; i < SB; i++) begin
      run         = run & wr_strb[i];
      run_mask[i] = run;
      vbytes      = vbytes + 5'(run);
    end
    keep = wr_last ? run_mask : wr_strb;
    bad  = wr_last ? |(wr_strb & ~run_mask) : ~&wr_strb;
    for (int i = 0; i < SB; i++) begin
      word_m[i*8 +: 8] = keep[i] ? wr_data[i*8 +: 8] : 8'h00;
    end
    nbytes = 5'(lane) * 5'(SB) + (wr_last ? vbytes : 5'(SB));
    merged = asm_q | (128'(word_m) << (32'(lane) * BUS_W));
    padded = merged;
    if ((PAD_EN != 0) && wr_last && (nbytes < 5'd16)) begin
      padded = merged | (128'h1 << {nbytes, 3'b000});
    end
    push_dat = '{last: wr_last, nbytes: nbytes, data: padded};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      asm_q    <= '0;
      lane     <= '0;
      err_strb <= 1'b0;
    end else if (clear) begin
      asm_q    <= '0;
      lane     <= '0;
      err_strb <= 1'b0;
    end else begin
      err_strb <= acc && bad;
      if (commit) begin
        asm_q <= '0;
        lane  <= '0;
      end else if (acc) begin
        asm_q <= merged;
        lane  <= lane + 1'b1;
      end
    end
  end

  fifo #(.W($bits(blk_t)), .DEPTH(DEPTH)) u_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .clear    (clear),
    .push_vld (commit),
    .push_dat (push_dat),
    .pop_vld  (blk_valid),
    .pop_rdy  (blk_ready),
    .pop_dat  (pop_dat),
    .level    (level)
  );

  assign blk_last   = pop_dat.last;
  assign blk_nbytes = pop_dat.nbytes;
  assign blk_data   = pop_dat.data;
endmodule
